image_pixel_fetch: RTL and testbench
====================================

// Module: image_pixel_fetch
// PURPOSE
// - Stage between vgaController and videoGen: turns raster (x,y) into pixel-ROM reads for a centred IMAGE_WIDTH x IMAGE_HEIGHT image.
// - Expands the ROM word to 8-bit r/g/b and fills outside the image window with BG_COLOR.
// - Delays hsync/vsync/blank_b so all outputs stay aligned with the pixel they belong to.
// PARAMETERS
// - IMAGE_WIDTH   400       image columns
// - IMAGE_HEIGHT  400       image rows
// - H_ACTIVE      640       visible pixels per line
// - V_ACTIVE      480       visible lines per frame
// - RGBFormat     1         0: 8-bit grayscale word (same value on r/g/b); 1: RGB332 word
// - ADDR_W        18        ROM address width; must satisfy 2**ADDR_W >= IMAGE_WIDTH*IMAGE_HEIGHT
// - BG_COLOR      24'h000000  {r,g,b} driven outside the image window
// PORTS
// - clk          in   1       pixel clock (vgaclk domain)
// - reset        in   1       asynchronous, active-high
// - x            in   10      raster column from vgaController
// - y            in   10      raster row from vgaController
// - hsync_i      in   1       active-low hsync from vgaController
// - vsync_i      in   1       active-low vsync from vgaController
// - blank_b_i    in   1       high = visible region
// - mem_addr     out  ADDR_W  pixel ROM address
// - mem_rd_en    out  1       read strobe
// - mem_rdata    in   8       ROM data; synchronous, valid exactly 1 cycle after mem_addr/mem_rd_en
// - hsync_o      out  1       hsync_i delayed 3 cycles
// - vsync_o      out  1       vsync_i delayed 3 cycles
// - blank_b_o    out  1       blank_b_i delayed 3 cycles
// - r, g, b      out  8 each  pixel colour, aligned with the delayed syncs
// - frame_done   out  1       1-cycle pulse when the last image pixel leaves on r/g/b
// BEHAVIOUR
// - Reset values: mem_addr=0, mem_rd_en=0, hsync_o=1, vsync_o=1, blank_b_o=0, r=g=b=0, frame_done=0; address counter 0; all pipeline valid bits 0.
// - Window: X0=(H_ACTIVE-IMAGE_WIDTH)/2, Y0=(V_ACTIVE-IMAGE_HEIGHT)/2 (120, 40 at defaults).
//   in_win = blank_b_i && X0<=x<X0+IMAGE_WIDTH && Y0<=y<Y0+IMAGE_HEIGHT.
// - Address counter, no multiplier:
//   - Cleared to 0 on the cycle x==0 && y==0.
//   - Otherwise incremented by 1 on every in_win cycle.
//   - Saturates at IMAGE_WIDTH*IMAGE_HEIGHT-1 and never wraps mid-frame.
// - Pipeline:
//   - S1 (cycle +1): mem_addr=counter, mem_rd_en=in_win; win1 = in_win.
//   - S2 (cycle +2): mem_rdata valid; win2 = win1.
//   - S3 (cycle +3): r/g/b registered.
//   - Syncs and blank_b pass through a 3-deep shift register, so input-to-output latency is 3 cycles for every output.
// - Colour expansion at S3:
//   - win2=0 -> BG_COLOR.
//   - RGBFormat=0 -> r=g=b=d.
//   - RGBFormat=1 -> r={d[7:5],d[7:5],d[7:6]}, g={d[4:2],d[4:2],d[4:3]}, b={4{d[1:0]}}.
//   - blank_b delayed=0 -> r=g=b=0, overriding BG_COLOR.
// - frame_done: asserted at S3 for the pixel whose address was IMAGE_WIDTH*IMAGE_HEIGHT-1 (address carried down the pipe as last-flag).
// - mem_rd_en is low outside the window, so the ROM is not read there.
// - Reset mid-frame: everything returns to reset values at once. After release, output is BG/black until the next x==0 && y==0, then correct from address 0.
// - x/y sequence skipping (0,0): the counter keeps counting and saturates; no X-propagation, no out-of-range address.
// STRUCTURE
// - Shared package vga_pkg: H_ACTIVE, V_ACTIVE constants, SYNC_ACTIVE_LOW constant, typedef rgb_t {r,g,b}, function rgb332_expand.
// - One sub-module: sync_delay #(DEPTH=3, W=3) carrying {hsync, vsync, blank_b} with its own reset values.
// - Counter, window compare and colour mux stay in this module.
// TESTING
// - Reset held, then released: outputs equal reset values; first (0,0) -> mem_addr 0; first output 3 cycles after input.
// - Sweep one full 640x480 frame with ROM data = addr[7:0]:
//   - (120,40) -> mem_addr 0; (519,40) -> 399; (120,41) -> 400; (519,439) -> 159999.
//   - frame_done pulses exactly once, 3 cycles after (519,439).
// - RGBFormat=1, ROM word 8'b101_011_10 -> r=8'hB6, g=8'h6D, b=8'hAA; RGBFormat=0, word 8'h5A -> r=g=b=8'h5A.
// - Pixel (10,10) with BG_COLOR=24'h123456 -> r=12, g=34, b=56 and mem_rd_en=0; blank_b_i=0 -> r=g=b=0.
// - Toggle hsync_i/vsync_i in a random pattern -> hsync_o/vsync_o equal the inputs delayed exactly 3 cycles.
// - Assert reset at (300,200) for 2 cycles, then resume:
//   - Black output until the next (0,0).
//   - Following frame's addresses identical to a clean frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: raster geometry, sync polarity, packed colour type
// and the RGB332 to 24-bit colour expansion.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam bit SYNC_ACTIVE_LOW = 1'b1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bit replication spreads each field over the full 8-bit range.
  function automatic rgb_t rgb332_expand(input logic [7:0] d);
    rgb_t c;
    c.r = {d[7:5], d[7:5], d[7:6]};
    c.g = {d[4:2], d[4:2], d[4:3]};
    c.b = {4{d[1:0]}};
    return c;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register for the raster control bits, so they leave the
// block together with the pixel they were sampled with.
module sync_delay #(
  parameter int              DEPTH   = 3,
  parameter int              W       = 3,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/image_pixel_fetch.sv
// Maps raster (x,y) onto pixel-ROM reads for a centred image, expands the ROM
// word to r/g/b and keeps syncs, blank and colour aligned at 3 cycles latency.
module image_pixel_fetch
  import vga_pkg::*;
#(
  parameter int          IMAGE_WIDTH  = 400,
  parameter int          IMAGE_HEIGHT = 400,
  parameter int          H_ACTIVE     = vga_pkg::H_ACTIVE,
  parameter int          V_ACTIVE     = vga_pkg::V_ACTIVE,
  parameter int          RGBFormat    = 1,
  parameter int          ADDR_W       = 18,
  parameter logic [23:0] BG_COLOR     = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              blank_b_i,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              blank_b_o,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              frame_done
);

  localparam int          X0_I = (H_ACTIVE - IMAGE_WIDTH) / 2;
  localparam int          Y0_I = (V_ACTIVE - IMAGE_HEIGHT) / 2;
  localparam logic [9:0]  X0   = 10'(X0_I);
  localparam logic [9:0]  X1   = 10'(X0_I + IMAGE_WIDTH);
  localparam logic [9:0]  Y0   = 10'(Y0_I);
  localparam logic [9:0]  Y1   = 10'(Y0_I + IMAGE_HEIGHT);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

  logic              synced;
  logic              at_origin;
  logic              in_win;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_now;
  logic [ADDR_W-1:0] cnt_next;
  logic              win1, win2;
  logic              last1, last2;
  logic              blank1, blank2;
  rgb_t              pix;
  logic [2:0]        ctl_q;

  // Until the first (0,0) after reset the counter has no frame reference, so
  // the window is suppressed and the output shows background only.
  assign at_origin = (x == 10'd0) && (y == 10'd0);
  assign in_win    = blank_b_i && (synced || at_origin) &&
                     (x >= X0) && (x < X1) && (y >= Y0) && (y < Y1);
  assign addr_now  = at_origin ? '0 : cnt;
  assign cnt_next  = (in_win && (addr_now != LAST)) ? addr_now + ADDR_W'(1) : addr_now;

  // ROM interface: a read is issued whenever mem_rd_en is high, there is no
  // back-pressure, and mem_rdata holds that word exactly one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      synced    <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      win1      <= 1'b0;
      last1     <= 1'b0;
      blank1    <= 1'b0;
      win2      <= 1'b0;
      last2     <= 1'b0;
      blank2    <= 1'b0;
      r         <= 8'h00;
      g         <= 8'h00;
      b         <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      synced    <= synced | at_origin;
      cnt       <= cnt_next;
      mem_addr  <= addr_now;
      mem_rd_en <= in_win;
      win1      <= in_win;
      last1     <= in_win && (addr_now == LAST);
      blank1    <= blank_b_i;
      win2      <= win1;
      last2     <= last1;
      blank2    <= blank1;
      r         <= pix.r;
      g         <= pix.g;
      b         <= pix.b;
      frame_done <= last2;
    end
  end

  always_comb begin
    pix = rgb_t'(BG_COLOR);
    if (!blank2) begin
      pix = '0;
    end else if (win2) begin
      if (RGBFormat == 1) pix = rgb332_expand(mem_rdata);
      else                pix = '{r: mem_rdata, g: mem_rdata, b: mem_rdata};
    end
  end

  sync_delay #(
    .DEPTH   (3),
    .W       (3),
    .RST_VAL ({SYNC_ACTIVE_LOW, SYNC_ACTIVE_LOW, 1'b0})
  ) u_sync_delay (
    .clk (clk),
    .rst (reset),
    .d   ({hsync_i, vsync_i, blank_b_i}),
    .q   (ctl_q)
  );

  assign {hsync_o, vsync_o, blank_b_o} = ctl_q;

endmodule

// File: tb/tb_image_pixel_fetch.sv
// Directed bench: a default-geometry RGB332 instance and a small grayscale
// instance (8x6 image in a 16x12 raster) for full-frame sweeps.
module tb_image_pixel_fetch;

  logic        clk;
  logic        reset;
  logic [9:0]  x, y;
  logic        hsync_i, vsync_i, blank_b_i;

  logic [17:0] mem_addr_a;
  logic        rd_en_a, hs_a, vs_a, bl_a, fd_a;
  logic [7:0]  rdata_a, r_a, g_a, b_a;
  logic        ovr_a_en;
  logic [7:0]  ovr_a;

  logic [5:0]  mem_addr_b;
  logic        rd_en_b, hs_b, vs_b, bl_b, fd_b;
  logic [7:0]  rdata_b, r_b, g_b, b_b;
  logic        ovr_b_en;
  logic [7:0]  ovr_b;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];
  logic [2:0]  sync_q[$];

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and ROM models
  image_pixel_fetch #(
    .RGBFormat (1),
    .BG_COLOR  (24'h123456)
  ) dut_a (
    .clk (clk), .reset (reset), .x (x), .y (y),
    .hsync_i (hsync_i), .vsync_i (vsync_i), .blank_b_i (blank_b_i),
    .mem_addr (mem_addr_a), .mem_rd_en (rd_en_a), .mem_rdata (rdata_a),
    .hsync_o (hs_a), .vsync_o (vs_a), .blank_b_o (bl_a),
    .r (r_a), .g (g_a), .b (b_a), .frame_done (fd_a)
  );

  image_pixel_fetch #(
    .IMAGE_WIDTH (8), .IMAGE_HEIGHT (6), .H_ACTIVE (16), .V_ACTIVE (12),
    .RGBFormat (0), .ADDR_W (6), .BG_COLOR (24'h000000)
  ) dut_b (
    .clk (clk), .reset (reset), .x (x), .y (y),
    .hsync_i (hsync_i), .vsync_i (vsync_i), .blank_b_i (blank_b_i),
    .mem_addr (mem_addr_b), .mem_rd_en (rd_en_b), .mem_rdata (rdata_b),
    .hsync_o (hs_b), .vsync_o (vs_b), .blank_b_o (bl_b),
    .r (r_b), .g (g_b), .b (b_b), .frame_done (fd_b)
  );

  always @(posedge clk) rdata_a <= ovr_a_en ? ovr_a : mem_addr_a[7:0];
  always @(posedge clk) rdata_b <= ovr_b_en ? ovr_b : {2'b00, mem_addr_b};

  // ---------------- checker and driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; on return the S1 registers hold this pixel.
  task automatic drive(input int xx, input int yy, input logic bl);
    x = 10'(xx);
    y = 10'(yy);
    blank_b_i = bl;
    @(negedge clk);
  endtask

  // Full small-instance frame; expected address from row/column arithmetic.
  task automatic sweep_small();
    int fd_cnt;
    logic [24:0] e;
    fd_cnt = 0;
    exp_q.delete();
    for (int yy = 0; yy < 14; yy++) begin
      for (int xx = 0; xx < 20; xx++) begin
        logic bl, win;
        int a;
        logic [7:0] a8;
        bl  = (xx < 16) && (yy < 12);
        win = bl && (xx >= 4) && (xx < 12) && (yy >= 3) && (yy < 9);
        a   = (yy - 3) * 8 + (xx - 4);
        a8  = 8'(a);
        drive(xx, yy, bl);
        chk("small_rd_en", 32'(rd_en_b), 32'(win));
        if (win) chk("small_addr", 32'(mem_addr_b), 32'(a));
        exp_q.push_back(win ? {(a == 47), a8, a8, a8} : 25'h0);
        if (fd_b) fd_cnt++;
        if (exp_q.size() == 3) begin
          e = exp_q.pop_front();
          chk("small_pix", 32'({fd_b, r_b, g_b, b_b}), 32'(e));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(19, 13, 1'b0);
      exp_q.push_back(25'h0);
      if (fd_b) fd_cnt++;
      e = exp_q.pop_front();
      chk("small_pix_tail", 32'({fd_b, r_b, g_b, b_b}), 32'(e));
    end
    exp_q.delete();
    chk("frame_done_count", 32'(fd_cnt), 32'd1);
  endtask

  // ---------------- directed sequence
  initial begin
    logic [2:0] s;
    reset = 1'b1;
    x = '0; y = '0;
    hsync_i = 1'b1; vsync_i = 1'b1; blank_b_i = 1'b0;
    ovr_a_en = 1'b0; ovr_a = 8'h00;
    ovr_b_en = 1'b0; ovr_b = 8'h00;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    chk("rst_rd_en", 32'(rd_en_a), 32'd0);
    chk("rst_syncs", 32'({hs_a, vs_a, bl_a}), 32'b110);
    chk("rst_rgb", 32'({r_a, g_a, b_a}), 32'h0);
    chk("rst_frame_done", 32'(fd_a), 32'd0);
    chk("rst_rgb_b", 32'({r_b, g_b, b_b, fd_b}), 32'h0);
    reset = 1'b0;

    // first (0,0) and 3-cycle latency
    drive(0, 0, 1'b1);
    chk("origin_addr", 32'(mem_addr_a), 32'd0);
    chk("latency_c1", 32'(bl_a), 32'd0);
    drive(1, 0, 1'b1);
    chk("latency_c2", 32'(bl_a), 32'd0);
    drive(2, 0, 1'b1);
    chk("latency_c3_blank", 32'(bl_a), 32'd1);
    chk("latency_c3_rgb", 32'({r_a, g_a, b_a}), 32'h123456);

    // default-geometry addressing, rows 40 and 41
    for (int xx = 118; xx < 522; xx++) begin
      drive(xx, 40, 1'b1);
      if (xx == 118) chk("row40_pre_rd_en", 32'(rd_en_a), 32'd0);
      if (xx == 120) chk("addr_120_40", 32'({rd_en_a, mem_addr_a}), 32'({1'b1, 18'd0}));
      if (xx == 519) chk("addr_519_40", 32'({rd_en_a, mem_addr_a}), 32'({1'b1, 18'd399}));
      if (xx == 520) chk("row40_post_rd_en", 32'(rd_en_a), 32'd0);
    end
    for (int xx = 119; xx < 122; xx++) begin
      drive(xx, 41, 1'b1);
      if (xx == 120) chk("addr_120_41", 32'(mem_addr_a), 32'd400);
      if (xx == 121) chk("addr_121_41", 32'(mem_addr_a), 32'd401);
    end

    // RGB332 expansion
    ovr_a_en = 1'b1; ovr_a = 8'b101_011_10;
    repeat (3) drive(200, 100, 1'b1);
    chk("rgb332_r", 32'(r_a), 32'hB6);
    chk("rgb332_g", 32'(g_a), 32'h6D);
    chk("rgb332_b", 32'(b_a), 32'hAA);
    ovr_a_en = 1'b0;

    // background outside window, black in blanking
    drive(10, 10, 1'b1);
    chk("bg_rd_en", 32'(rd_en_a), 32'd0);
    drive(10, 10, 1'b1);
    drive(10, 10, 1'b1);
    chk("bg_rgb", 32'({r_a, g_a, b_a}), 32'h123456);
    repeat (3) drive(10, 10, 1'b0);
    chk("blank_rgb", 32'({r_a, g_a, b_a}), 32'h0);

    // grayscale on the small instance
    ovr_b_en = 1'b1; ovr_b = 8'h5A;
    repeat (3) drive(5, 5, 1'b1);
    chk("gray_rgb", 32'({r_b, g_b, b_b}), 32'h5A5A5A);
    ovr_b_en = 1'b0;

    // random sync pattern, 3-cycle delay
    sync_q.delete();
    for (int i = 0; i < 24; i++) begin
      hsync_i = 1'($urandom_range(0, 1));
      vsync_i = 1'($urandom_range(0, 1));
      blank_b_i = 1'($urandom_range(0, 1));
      s = {hsync_i, vsync_i, blank_b_i};
      drive(600, 460, blank_b_i);
      sync_q.push_back(s);
      if (sync_q.size() == 3) chk("sync_delay", 32'({hs_a, vs_a, bl_a}), 32'(sync_q.pop_front()));
    end
    hsync_i = 1'b1; vsync_i = 1'b1;

    // reset at (300,200) on the default instance
    drive(0, 0, 1'b1);
    drive(299, 200, 1'b1);
    drive(300, 200, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_a_vals", 32'({rd_en_a, fd_a, r_a, g_a, b_a}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int xx = 301; xx < 311; xx++) begin
      drive(xx, 200, 1'b1);
      chk("midrst_a_rd_en", 32'(rd_en_a), 32'd0);
      if (xx >= 303) chk("midrst_a_bg", 32'({r_a, g_a, b_a}), 32'h123456);
    end
    drive(0, 0, 1'b1);
    drive(120, 40, 1'b1);
    chk("midrst_a_resume", 32'({rd_en_a, mem_addr_a}), 32'({1'b1, 18'd0}));

    // clean small frame
    sweep_small();

    // small frame interrupted by reset at (7,5)
    for (int p = 0; p <= 5 * 20 + 7; p++) begin
      drive(p % 20, p / 20, (p % 20 < 16) && (p / 20 < 12));
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_b_vals", 32'({rd_en_b, fd_b, bl_b, r_b, g_b, b_b}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int p = 5 * 20 + 8; p < 14 * 20; p++) begin
      drive(p % 20, p / 20, (p % 20 < 16) && (p / 20 < 12));
      chk("midrst_b_rd_en", 32'(rd_en_b), 32'd0);
      chk("midrst_b_black", 32'({fd_b, r_b, g_b, b_b}), 32'h0);
    end

    // following frame must match a clean frame
    sweep_small();

    // no (0,0): counter holds at the last address
    drive(4, 3, 1'b1);
    chk("saturate_addr", 32'({rd_en_b, mem_addr_b}), 32'({1'b1, 6'd47}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
